hazard_ctrl_pipe: RTL

HAZARD_CTRL_PIPE -- requirements
Module: hazard_ctrl_pipe

---
 rtl/hazard_ctrl_pipe.sv | 88 ++++++++
 1 files changed

// File: rtl/hazard_ctrl_pipe.sv
// hazard_ctrl_pipe: D->E->M->W control pipeline registers with forwarding, stall and flush generation.
module hazard_ctrl_pipe (
  input  logic       clk,
  input  logic       reset,
  input  logic       PCSD,
  input  logic       RegWD,
  input  logic       MemWD,
  input  logic       BranchD,
  input  logic       MemtoRegD,
  input  logic       ALUSrcD,
  input  logic       BEDmemD,
  input  logic       BLD,
  input  logic [3:0] ALUControlD,
  input  logic [3:0] CondD,
  input  logic [1:0] FlagWD,
  input  logic [3:0] RA1D,
  input  logic [3:0] RA2D,
  input  logic [3:0] WA3D,
  input  logic       PCSrcEO,
  input  logic       RegWriteEO,
  input  logic       MemWriteEO,
  input  logic       BranchEO,
  output logic [3:0] CondE,
  output logic [1:0] FlagWE,
  output logic       PCSE,
  output logic       RegWE,
  output logic       MemWE,
  output logic       BranchE,
  output logic       MemtoRegE,
  output logic       ALUSrcE,
  output logic       BEDmemE,
  output logic       BLE,
  output logic [3:0] ALUControlE,
  output logic       RegWriteM,
  output logic       MemWriteM,
  output logic       MemtoRegM,
  output logic       PCSrcM,
  output logic       BEDmemM,
  output logic       BLM,
  output logic [3:0] WA3M,
  output logic       RegWriteW,
  output logic       MemtoRegW,
  output logic       PCSrcW,
  output logic       BLW,
  output logic [3:0] WA3W,
  output logic [1:0] ForwardAE,
  output logic [1:0] ForwardBE,
  output logic       StallF,
  output logic       StallD,
  output logic       FlushD,
  output logic       FlushE
);
  logic [3:0] ra1_e, ra2_e, wa3_e;
  logic       ldrstall, pcpend;
  always_ff @(posedge clk or posedge reset)
    if (reset)
      {PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE, BEDmemE, BLE, ALUControlE, CondE, FlagWE,
       ra1_e, ra2_e, wa3_e} <= '0;
    else if (FlushE)
      {PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE, BEDmemE, BLE, ALUControlE, CondE, FlagWE,
       ra1_e, ra2_e, wa3_e} <= '0;
    else
      {PCSE, RegWE, MemWE, BranchE, MemtoRegE, ALUSrcE, BEDmemE, BLE, ALUControlE, CondE, FlagWE,
       ra1_e, ra2_e, wa3_e} <= {PCSD, RegWD, MemWD, BranchD, MemtoRegD, ALUSrcD, BEDmemD, BLD,
                                ALUControlD, CondD, FlagWD, RA1D, RA2D, WA3D};
  // E->M takes the condition-gated results, so a failed condition never writes
  always_ff @(posedge clk or posedge reset)
    if (reset)
      {RegWriteM, MemWriteM, PCSrcM, MemtoRegM, BEDmemM, BLM, WA3M} <= '0;
    else
      {RegWriteM, MemWriteM, PCSrcM, MemtoRegM, BEDmemM, BLM, WA3M} <=
        {RegWriteEO, MemWriteEO, PCSrcEO, MemtoRegE, BEDmemE, BLE, wa3_e};
  always_ff @(posedge clk or posedge reset)
    if (reset)
      {RegWriteW, MemtoRegW, PCSrcW, BLW, WA3W} <= '0;
    else
      {RegWriteW, MemtoRegW, PCSrcW, BLW, WA3W} <= {RegWriteM, MemtoRegM, PCSrcM, BLM, WA3M};
  assign ForwardAE = (RegWriteM && ra1_e == WA3M) ? 2'b10 :
                     (RegWriteW && ra1_e == WA3W) ? 2'b01 : 2'b00;
  assign ForwardBE = (RegWriteM && ra2_e == WA3M) ? 2'b10 :
                     (RegWriteW && ra2_e == WA3W) ? 2'b01 : 2'b00;
  assign ldrstall = MemtoRegE & RegWE & ((RA1D == wa3_e) | (RA2D == wa3_e));
  assign pcpend   = PCSD | PCSE | PCSrcM;
  assign StallF   = ldrstall | pcpend;
  assign StallD   = ldrstall;
  assign FlushD   = pcpend | PCSrcW | BranchEO;
  assign FlushE   = ldrstall | BranchEO;
endmodule
